divider: RTL and testbench

Sequential 16-bit integer divider for the execute stage. It sits beside the ALU adder and its overflow detector and provides the inverse arithmetic path: it accepts a dividend and divisor with a signed/unsigned select and produces quotient and remainder using one restoring-division step per cycle. It also raises divide-by-zero and signed-overflow flags, which the same exception logic consumes as the adder overflow flag. The pipeline stalls on `busy` and captures results on the `done` pulse.

---
 rtl/divider.sv | 124 ++++++++++++
 tb/tb_divider.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential 16-bit restoring divider, one quotient bit per cycle.
// Signed mode truncates toward zero; remainder follows dividend sign.
module divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             of
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_r, b_r;
    logic             sign_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH:0]   r_r;
    logic [WIDTH:0]   bmag;
    logic [3:0]       cnt;

    logic             accept;
    logic             b_zero;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] diff;
    logic             q_neg, r_neg;

    assign accept = start && (state == IDLE || state == DONE);
    assign b_zero = (B == '0);
    assign busy   = (state == DIV) || (state == FIX);
    assign done   = (state == DONE);

    // 0x8000 negates to itself and is read as unsigned 0x8000
    assign a_abs = (sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_abs = (sign && B[WIDTH-1]) ? (~B + 1'b1) : B;

    assign r_sh = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
    assign diff = {1'b0, r_sh} - {1'b0, bmag};

    assign q_neg = sign_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    assign r_neg = sign_r && a_r[WIDTH-1];

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = b_zero ? DONE : DIV;
            DIV:  if (cnt == 4'd15) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: begin
                if (start) state_n = b_zero ? DONE : DIV;
                else       state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            q_r       <= '0;
            r_r       <= '0;
            bmag      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            of        <= 1'b0;
        end else if (accept) begin
            a_r    <= A;
            b_r    <= B;
            sign_r <= sign;
            of     <= 1'b0;
            cnt    <= '0;
            r_r    <= '0;
            q_r    <= a_abs;
            bmag   <= {1'b0, b_abs};
            if (b_zero) begin
                dz        <= 1'b1;
                quotient  <= '1;
                remainder <= A;
            end else begin
                dz        <= 1'b0;
                quotient  <= '0;
                remainder <= '0;
            end
        end else if (state == DIV) begin
            cnt <= cnt + 4'd1;
            if (!diff[WIDTH+1]) begin
                r_r <= diff[WIDTH:0];
                q_r <= {q_r[WIDTH-2:0], 1'b1};
            end else begin
                r_r <= r_sh;
                q_r <= {q_r[WIDTH-2:0], 1'b0};
            end
        end else if (state == FIX) begin
            quotient  <= q_neg ? (~q_r + 1'b1) : q_r;
            remainder <= r_neg ? (~r_r[WIDTH-1:0] + 1'b1) : r_r[WIDTH-1:0];
            of        <= sign_r && (a_r == 16'h8000) && (b_r == 16'hFFFF);
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: latency, signed fixup, overflow,
// divide-by-zero, ignored start, mid-operation reset, back-to-back.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A, B;
    logic        sign;
    logic        busy, done, dz, of;
    logic [15:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    divider dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sign(sign),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .dz(dz), .of(of)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic s);
        A = a; B = b; sign = s; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle 1; returns in cycle 18 after checking results.
    task automatic track(input string tag, input logic [15:0] eq,
                         input logic [15:0] er, input logic eof,
                         input int poke);
        for (int c = 1; c <= 17; c++) begin
            if (c == poke) begin
                A = 16'hFFFF; B = 16'h0001; sign = 1'b0; start = 1'b1;
            end
            check({tag, "_busy"}, {15'd0, busy}, 16'd1);
            check({tag, "_nodone"}, {15'd0, done}, 16'd0);
            tick();
            start = 1'b0;
        end
        check({tag, "_done"}, {15'd0, done}, 16'd1);
        check({tag, "_idle"}, {15'd0, busy}, 16'd0);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, {15'd0, dz}, 16'd0);
        check({tag, "_of"}, {15'd0, of}, {15'd0, eof});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {15'd0, busy}, 16'd0);
        check({tag, "_done"}, {15'd0, done}, 16'd0);
        check({tag, "_q"}, quotient, 16'd0);
        check({tag, "_r"}, remainder, 16'd0);
        check({tag, "_dz"}, {15'd0, dz}, 16'd0);
        check({tag, "_of"}, {15'd0, of}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; sign = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");

        launch(16'hFFFF, 16'h0010, 1'b0);
        track("unsigned", 16'h0FFF, 16'h000F, 1'b0, 0);
        tick();
        check("after_done", {15'd0, done}, 16'd0);

        launch(16'hFFF9, 16'h0002, 1'b1);
        track("neg_by_pos", 16'hFFFD, 16'hFFFF, 1'b0, 0);
        tick();

        launch(16'h0007, 16'hFFFE, 1'b1);
        track("pos_by_neg", 16'hFFFD, 16'h0001, 1'b0, 0);
        tick();

        launch(16'h8000, 16'hFFFF, 1'b1);
        track("ovf_signed", 16'h8000, 16'h0000, 1'b1, 0);
        tick();

        launch(16'h8000, 16'hFFFF, 1'b0);
        track("ovf_unsigned", 16'h0000, 16'h8000, 1'b0, 0);
        tick();

        launch(16'h1234, 16'h0000, 1'b0);
        check("dz_done", {15'd0, done}, 16'd1);
        check("dz_flag", {15'd0, dz}, 16'd1);
        check("dz_busy", {15'd0, busy}, 16'd0);
        check("dz_q", quotient, 16'hFFFF);
        check("dz_r", remainder, 16'h1234);
        tick();
        check("dz_after", {15'd0, done}, 16'd0);
        check("dz_after_busy", {15'd0, busy}, 16'd0);

        launch(16'h0064, 16'h0007, 1'b0);
        track("ignored_start", 16'h000E, 16'h0002, 1'b0, 5);
        tick();
        check("ignored_idle", {15'd0, busy}, 16'd0);

        launch(16'hFFFF, 16'h0003, 1'b0);
        for (int c = 1; c < 8; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midreset");
        for (int c = 0; c < 20; c++) begin
            check("midreset_nodone", {15'd0, done | busy}, 16'd0);
            tick();
        end

        launch(16'h00FF, 16'h0010, 1'b0);
        track("b2b_first", 16'h000F, 16'h000F, 1'b0, 0);
        launch(16'h0064, 16'h0007, 1'b0);
        track("b2b_second", 16'h000E, 16'h0002, 1'b0, 0);
        tick();
        check("b2b_end", {15'd0, done}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
